// File: rtl/exmem_arbiter.sv
// Two-master round-robin arbiter onto a single downstream memory port, with timeout abort.
// Latency: grant one cycle after valid; ack is combinational with s_ack or the timeout cycle.
// Backpressure: masters hold valid until ack; one request outstanding; IDLE gap after each completion.
module exmem_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_dat_o,
  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_dat_o,
  output logic        s_valid,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr,
  input  logic        s_ack,
  input  logic [31:0] s_dat_i,
  output logic        busy
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic [CW-1:0] r_cnt;
  logic          r_s_we;
  logic [3:0]    r_s_sel;
  logic [31:0]   r_s_dat;
  logic [31:0]   r_s_adr;

  logic w_busy;
  logic w_grant0;
  logic w_grant1;
  logic w_timeout;
  logic w_done;

  // A tie goes to whichever master was not served last.
  assign w_busy    = (r_state != IDLE);
  assign w_grant0  = (r_state == IDLE) && m0_valid && (!m1_valid || r_last_grant);
  assign w_grant1  = (r_state == IDLE) && m1_valid && (!m0_valid || !r_last_grant);
  // A real ack in the final cycle beats the timeout.
  assign w_timeout = w_busy && !s_ack && (r_cnt == CW'(TIMEOUT - 1));
  assign w_done    = w_busy && (s_ack || w_timeout);

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state: grant from IDLE, return to IDLE on ack or timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant0)      w_next = GRANT0;
        else if (w_grant1) w_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (w_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Latch the granted request, track last grant, and count cycles waiting for ack.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_s_we       <= 1'b0;
      r_s_sel      <= '0;
      r_s_dat      <= '0;
      r_s_adr      <= '0;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
      r_cnt        <= '0;
      r_s_we       <= m0_we;
      r_s_sel      <= m0_sel;
      r_s_dat      <= m0_dat_i;
      r_s_adr      <= m0_adr;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_s_we       <= m1_we;
      r_s_sel      <= m1_sel;
      r_s_dat      <= m1_dat_i;
      r_s_adr      <= m1_adr;
    end else if (w_busy && !s_ack) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Completion response to the granted master only; masked while reset is asserted.
  always_comb begin
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_o = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_o = '0;
    if (wb_rst_n && w_done) begin
      if (r_state == GRANT0) begin
        m0_ack   = 1'b1;
        m0_err   = !s_ack;
        m0_dat_o = s_ack ? s_dat_i : ERR_DATA;
      end else if (r_state == GRANT1) begin
        m1_ack   = 1'b1;
        m1_err   = !s_ack;
        m1_dat_o = s_ack ? s_dat_i : ERR_DATA;
      end
    end
  end

  assign s_valid = w_busy;
  assign busy    = w_busy;
  assign s_we    = r_s_we;
  assign s_sel   = r_s_sel;
  assign s_dat_o = r_s_dat;
  assign s_adr   = r_s_adr;

endmodule

// File: tb/tb_exmem_arbiter.sv
module tb_exmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m0_we, m1_valid, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_dat_i, m0_adr, m1_dat_i, m1_adr;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_valid, s_we, s_ack, busy;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_o, s_adr, s_dat_i;

  typedef struct {
    logic        mst;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  exmem_arbiter dut (
    .wb_clk_i(clk),     .wb_rst_n(rst_n),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_sel(m0_sel), .m0_dat_i(m0_dat_i), .m0_adr(m0_adr),
    .m0_ack(m0_ack),     .m0_err(m0_err), .m0_dat_o(m0_dat_o),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_sel(m1_sel), .m1_dat_i(m1_dat_i), .m1_adr(m1_adr),
    .m1_ack(m1_ack),     .m1_err(m1_err), .m1_dat_o(m1_dat_o),
    .s_valid(s_valid),   .s_we(s_we), .s_sel(s_sel), .s_dat_o(s_dat_o), .s_adr(s_adr),
    .s_ack(s_ack),       .s_dat_i(s_dat_i),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard check of master responses at the sampling point of the current cycle.
  task automatic mon();
    exp_t e;
    if (m0_ack || m1_ack) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("ack_master", {30'd0, m1_ack, m0_ack}, e.mst ? 32'd2 : 32'd1);
        chk("ack_err", e.mst ? m1_err : m0_err, {31'd0, e.err});
        chk("ack_dat", e.mst ? m1_dat_o : m0_dat_o, e.dat);
        chk("other_err", e.mst ? m0_err : m1_err, 32'd0);
        chk("other_dat", e.mst ? m0_dat_o : m1_dat_o, 32'd0);
      end
    end else begin
      chk("err_without_ack", {30'd0, m1_err, m0_err}, 32'd0);
    end
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic fin();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    look();
    fin();
  endtask

  task automatic push(input logic mst, input logic err, input logic [31:0] dat);
    exp_t e;
    e.mst = mst;
    e.err = err;
    e.dat = dat;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_valid = 0; m0_we = 0; m0_sel = 0; m0_dat_i = 0; m0_adr = 0;
    m1_valid = 0; m1_we = 0; m1_sel = 0; m1_dat_i = 0; m1_adr = 0;
    s_ack = 0; s_dat_i = 0;

    // Reset state.
    @(posedge clk); #1;
    look();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_s_we", {31'd0, s_we}, 32'd0);
    chk("rst_s_sel", {28'd0, s_sel}, 32'd0);
    chk("rst_s_dat", s_dat_o, 32'd0);
    chk("rst_s_adr", s_adr, 32'd0);
    chk("rst_m_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_m_dat", m0_dat_o | m1_dat_o, 32'd0);
    fin();
    rst_n = 1'b1;

    // m0 read, downstream acks 10 cycles after s_valid.
    m0_valid = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h3800_0010;
    look(); chk("rd_idle_s_valid", {31'd0, s_valid}, 32'd0); fin();
    look();
    chk("rd_s_valid", {31'd0, s_valid}, 32'd1);
    chk("rd_busy", {31'd0, busy}, 32'd1);
    chk("rd_s_adr", s_adr, 32'h3800_0010);
    chk("rd_s_we", {31'd0, s_we}, 32'd0);
    fin();
    for (int i = 0; i < 9; i++) cyc();
    s_ack = 1; s_dat_i = 32'h1234_5678;
    push(0, 0, 32'h1234_5678);
    look();
    chk("rd_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("rd_m1_ack", {31'd0, m1_ack}, 32'd0);
    fin();
    m0_valid = 0; s_ack = 0;
    look();
    chk("rd_after_ack", {31'd0, m0_ack}, 32'd0);
    chk("rd_after_busy", {31'd0, busy}, 32'd0);
    fin();

    // m1 write, s_ack combinational in the first grant cycle.
    m1_valid = 1; m1_we = 1; m1_sel = 4'b0011; m1_dat_i = 32'hA5A5_A5A5; m1_adr = 32'h1000_0004;
    cyc();
    s_ack = 1; s_dat_i = 32'h0BAD_0001;
    push(1, 0, 32'h0BAD_0001);
    look();
    chk("wr_s_we", {31'd0, s_we}, 32'd1);
    chk("wr_s_sel", {28'd0, s_sel}, 32'h3);
    chk("wr_s_dat", s_dat_o, 32'hA5A5_A5A5);
    chk("wr_s_adr", s_adr, 32'h1000_0004);
    chk("wr_m1_ack", {31'd0, m1_ack}, 32'd1);
    fin();
    m1_valid = 0; s_ack = 0;
    look(); chk("wr_idle", {31'd0, s_valid}, 32'd0); fin();

    // Fresh reset, then both masters continuously request: 0,1,0,1.
    rst_n = 0; cyc(); rst_n = 1;
    m0_valid = 1; m0_we = 0; m0_adr = 32'h0000_00A0;
    m1_valid = 1; m1_we = 0; m1_adr = 32'h0000_00A1;
    for (int g = 0; g < 4; g++) begin
      look(); chk("rr_idle_gap", {31'd0, s_valid}, 32'd0); fin();
      look();
      chk("rr_busy", {31'd0, busy}, 32'd1);
      chk("rr_s_adr", s_adr, (g % 2 == 1) ? 32'h0000_00A1 : 32'h0000_00A0);
      fin();
      s_ack = 1; s_dat_i = 32'h100 + g;
      push((g % 2) == 1, 0, 32'h100 + g);
      cyc();
      s_ack = 0;
    end
    m0_valid = 0; m1_valid = 0;
    cyc();
    chk("rr_q_empty", q.size(), 32'd0);

    // m0 changes fields and drops valid mid-grant; request stays frozen and completes.
    m0_valid = 1; m0_we = 1; m0_sel = 4'hC; m0_adr = 32'h2000_0000; m0_dat_i = 32'h1111_1111;
    cyc();
    m0_adr = 32'h2000_0FFC; m0_dat_i = 32'h2222_2222; m0_we = 0; m0_sel = 4'h1;
    cyc();
    m0_valid = 0;
    look();
    chk("hold_s_adr", s_adr, 32'h2000_0000);
    chk("hold_s_dat", s_dat_o, 32'h1111_1111);
    chk("hold_s_sel", {28'd0, s_sel}, 32'hC);
    chk("hold_s_valid", {31'd0, s_valid}, 32'd1);
    fin();
    s_ack = 1; s_dat_i = 32'h0;
    push(0, 0, 32'h0);
    look(); chk("hold_m0_ack", {31'd0, m0_ack}, 32'd1); fin();
    s_ack = 0;
    cyc();

    // Timeout: no s_ack for TIMEOUT grant cycles.
    m0_valid = 1; m0_we = 0; m0_adr = 32'h3000_0000;
    cyc();
    for (int i = 0; i < 63; i++) cyc();
    push(0, 1, 32'hDEAD_BEEF);
    look();
    chk("to_m0_ack", {31'd0, m0_ack}, 32'd1);
    chk("to_m0_err", {31'd0, m0_err}, 32'd1);
    fin();
    m0_valid = 0;
    look();
    chk("to_s_valid", {31'd0, s_valid}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    fin();

    // s_ack arriving in the timeout cycle wins.
    m1_valid = 1; m1_we = 0; m1_adr = 32'h3000_0004;
    cyc();
    for (int i = 0; i < 63; i++) cyc();
    s_ack = 1; s_dat_i = 32'h5555_AAAA;
    push(1, 0, 32'h5555_AAAA);
    look(); chk("race_m1_err", {31'd0, m1_err}, 32'd0); fin();
    m1_valid = 0; s_ack = 0;
    cyc();

    // Reset three cycles into a grant, then a stray s_ack.
    m0_valid = 1; m0_adr = 32'h3800_0020;
    cyc();
    for (int i = 0; i < 3; i++) cyc();
    rst_n = 0; m0_valid = 0; s_ack = 1; s_dat_i = 32'h7777_7777;
    look(); chk("rstmid_m0_ack", {31'd0, m0_ack}, 32'd0); fin();
    rst_n = 1;
    look();
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
    fin();
    s_ack = 0;
    m1_valid = 1; m1_we = 1; m1_sel = 4'hF; m1_dat_i = 32'h0; m1_adr = 32'h3000_0008;
    cyc();
    look();
    chk("post_rst_s_adr", s_adr, 32'h3000_0008);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    fin();
    s_ack = 1; s_dat_i = 32'h0000_0042;
    push(1, 0, 32'h0000_0042);
    cyc();
    m1_valid = 0; s_ack = 0;
    cyc();

    chk("final_q_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
